// File: rtl/mac_result_collector.sv
// mac_result_collector
//  Tail of the MAC tree: folds TILES consecutive partial sums per (i,k) into a
//  wide result and queues finished results in a small FIFO. The FIFO drains
//  downstream over valid/ready. The input side has no backpressure, so overflow
//  and broken address sequences are flagged and never stalled.
// Ports
//  clk, reset                  clock; synchronous active-low reset
//  sum_in/addr_i_in/addr_k_in  partial sum beat and its (i,k) address
//  val_in                      beat valid (no ready)
//  out_sum/out_addr_i/_k       FIFO head, forced to 0 while out_val==0
//  out_val/out_rdy             FIFO non-empty / downstream accept
//  count                       FIFO occupancy 0..FIFO_DEPTH
//  ovf_err/seq_err             sticky: result dropped / address changed mid-group
//  clear_err                   clears both sticky flags (a new error wins)
module mac_result_collector #(
  parameter int SUM_WIDTH       = 32,
  parameter int ACC_WIDTH       = 40,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int TILES           = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [SUM_WIDTH-1:0]            sum_in,
  input  logic [ADDRESS_WIDTH_I-1:0]      addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0]      addr_k_in,
  input  logic                            val_in,
  output logic [ACC_WIDTH-1:0]            out_sum,
  output logic [ADDRESS_WIDTH_I-1:0]      out_addr_i,
  output logic [ADDRESS_WIDTH_K-1:0]      out_addr_k,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            ovf_err,
  output logic                            seq_err,
  input  logic                            clear_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = $clog2(TILES + 1);

  typedef struct packed {
    logic [ADDRESS_WIDTH_I-1:0] ai;
    logic [ADDRESS_WIDTH_K-1:0] ak;
    logic [ACC_WIDTH-1:0]       s;
  } res_t;

  logic [CW-1:0]              tile_cnt;
  logic [ACC_WIDTH-1:0]       acc;
  logic [ADDRESS_WIDTH_I-1:0] lat_i;
  logic [ADDRESS_WIDTH_K-1:0] lat_k;
  res_t                       mem [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;

  logic [ACC_WIDTH-1:0] ext, grp_sum;
  logic [CW-1:0]        nxt_cnt;
  logic                 addr_hit, restart, mis, done, full, pop, push, ovf;
  res_t                 head;

  always_comb begin
    ext      = ACC_WIDTH'(sum_in);
    addr_hit = (addr_i_in == lat_i) && (addr_k_in == lat_k);
    // A mismatching beat abandons the partial and starts a fresh group.
    restart  = (tile_cnt == '0) || !addr_hit;
    mis      = val_in && (tile_cnt != '0) && !addr_hit;
    grp_sum  = restart ? ext : acc + ext;
    nxt_cnt  = restart ? CW'(1) : tile_cnt + CW'(1);
    // The completing beat's sum goes straight into the FIFO.
    done     = val_in && (nxt_cnt == CW'(TILES));
    full     = (count == NW'(FIFO_DEPTH));
    pop      = out_val && out_rdy;
    // When full, a same-cycle pop frees the slot being written.
    push     = done && (!full || pop);
    ovf      = done && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tile_cnt <= '0;
      acc      <= '0;
      lat_i    <= '0;
      lat_k    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_err  <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      if (val_in) begin
        if (done) begin
          tile_cnt <= '0;
        end else begin
          tile_cnt <= nxt_cnt;
          acc      <= grp_sum;
          lat_i    <= addr_i_in;
          lat_k    <= addr_k_in;
        end
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      ovf_err <= ovf | (ovf_err & ~clear_err);
      seq_err <= mis | (seq_err & ~clear_err);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= '{ai: addr_i_in, ak: addr_k_in, s: grp_sum};
  end

  always_comb begin
    head       = mem[rd_ptr];
    out_val    = (count != '0);
    out_sum    = out_val ? head.s  : '0;
    out_addr_i = out_val ? head.ai : '0;
    out_addr_k = out_val ? head.ak : '0;
  end
endmodule
